// File: rtl/cbu_capture.sv
// cbu_capture: run controller and capture stage for a chain of cascaded
// 4-bit up-counter macros.
//
// Drives the chain's clear/enable/carry-in. Samples the chain's Q outputs
// on request or when a run ends, and presents each sample on a valid/ready
// port. Also tracks overflow and captures dropped on a busy port.
//
// Build option: define CBU_CAP_SAT_EN for saturating mode. The count then
// stops at all-ones and OVF is raised when all-ones is reached. When it is
// left undefined (the default), the count wraps and OVF follows CNT_CAO.
//
// Ports:
//   CLK      in   clock shared with the counter chain
//   CDN      in   asynchronous active-low reset
//   START    in   begin a new run (clear, then count)
//   STOP     in   end the current run and freeze the count
//   CAP      in   capture request during a run
//   CNT_Q    in   chain Q outputs, stage 0 in bits [3:0]
//   CNT_CAO  in   carry-out of the last stage
//   CNT_CD   out  clear to all stages
//   CNT_EN   out  enable to all stages
//   CNT_CAI  out  carry-in to stage 0
//   DATA     out  captured count
//   VALID    out  DATA holds an untransferred sample
//   READY    in   consumer accepts DATA
//   OVF      out  sticky overflow for the current run
//   LOST     out  sticky dropped-capture flag for the current run
//
// state | meaning
// IDLE  | after reset, chain held clear
// CLR   | one-cycle chain clear, sticky flags reset
// RUN   | chain counting, captures on CAP
// HOLD  | count frozen, final capture delivered once the slot frees

module cbu_capture #(
    parameter int NIB = 4
) (
    input  logic             CLK,
    input  logic             CDN,
    input  logic             START,
    input  logic             STOP,
    input  logic             CAP,
    input  logic [4*NIB-1:0] CNT_Q,
    input  logic             CNT_CAO,
    output logic             CNT_CD,
    output logic             CNT_EN,
    output logic             CNT_CAI,
    output logic [4*NIB-1:0] DATA,
    output logic             VALID,
    input  logic             READY,
    output logic             OVF,
    output logic             LOST
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t state;
    logic   pending;
    logic   slot_free;
    logic   run_cap;
    logic   final_cap;
    logic   ovf_hit;

    // The slot can take a new sample if empty, or if it empties at this edge.
    assign slot_free = !VALID || READY;
    assign run_cap   = (state == RUN) && CAP && slot_free;
    assign final_cap = (state == HOLD) && pending && slot_free;

    assign CNT_CD  = (state == IDLE) || (state == CLR);
    assign CNT_CAI = (state == RUN);

`ifdef CBU_CAP_SAT_EN
    logic count_full;
    logic cao_unused;

    assign count_full = &CNT_Q;
    assign cao_unused = CNT_CAO;
    // Only the count value gates the enable; there is no path from CNT_CAO.
    assign CNT_EN  = (state == RUN) && !count_full;
    assign ovf_hit = (state == RUN) && count_full;
`else
    assign CNT_EN  = (state == RUN);
    assign ovf_hit = (state == RUN) && CNT_CAO;
`endif

    always_ff @(posedge CLK or negedge CDN) begin
        if (!CDN) begin
            state   <= IDLE;
            pending <= 1'b0;
            DATA    <= '0;
            VALID   <= 1'b0;
            OVF     <= 1'b0;
            LOST    <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (START) state <= CLR;
                CLR:     state <= RUN;
                RUN: begin
                    if (START)     state <= CLR;
                    else if (STOP) state <= HOLD;
                end
                HOLD:    if (START) state <= CLR;
                default: state <= IDLE;
            endcase

            // A load at the same edge as a transfer keeps VALID high.
            if (run_cap || final_cap) begin
                DATA  <= CNT_Q;
                VALID <= 1'b1;
            end else if (READY) begin
                VALID <= 1'b0;
            end

            if (state == CLR) begin
                OVF     <= 1'b0;
                LOST    <= 1'b0;
                pending <= 1'b0;
            end else begin
                if (ovf_hit)
                    OVF <= 1'b1;
                if ((state == RUN) && CAP && !slot_free)
                    LOST <= 1'b1;
                // A restart wins over STOP, so no final capture is armed then.
                if ((state == RUN) && STOP && !START)
                    pending <= 1'b1;
                else if (final_cap)
                    pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cbu_capture.sv
// Directed bench for cbu_capture with NIB=1 and a behavioural 4-bit counter
// stage standing in for the macro chain. Expected values are hand-computed.
// Build with CBU_CAP_SAT_EN defined to check the saturating variant.

module tb_cbu_capture;

    logic       clk;
    logic       cdn;
    logic       start;
    logic       stop;
    logic       cap;
    logic       ready;
    logic [3:0] q;
    logic       cao;
    logic       cd;
    logic       en;
    logic       cai;
    logic [3:0] data;
    logic       valid;
    logic       ovf;
    logic       lost;

    int n_chk;
    int n_err;

    cbu_capture #(.NIB(1)) dut (
        .CLK     (clk),
        .CDN     (cdn),
        .START   (start),
        .STOP    (stop),
        .CAP     (cap),
        .CNT_Q   (q),
        .CNT_CAO (cao),
        .CNT_CD  (cd),
        .CNT_EN  (en),
        .CNT_CAI (cai),
        .DATA    (data),
        .VALID   (valid),
        .READY   (ready),
        .OVF     (ovf),
        .LOST    (lost)
    );

    // Single counter stage: synchronous clear, counts when enabled and carried in.
    always @(posedge clk) begin
        if (cd)
            q <= 4'd0;
        else if (en && cai)
            q <= q + 4'd1;
    end
    assign cao = cai && (&q);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        cdn   = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        cap   = 1'b0;
        ready = 1'b1;

        // Reset values before any clock edge.
        #3;
        chk("rst_cd",    32'(cd),    32'd1);
        chk("rst_en",    32'(en),    32'd0);
        chk("rst_cai",   32'(cai),   32'd0);
        chk("rst_data",  32'(data),  32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_ovf",   32'(ovf),   32'd0);
        chk("rst_lost",  32'(lost),  32'd0);
        step(1);
        cdn = 1'b1;
        step(1);

        // Capture 5 cycles after RUN entry.
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("clr_cd", 32'(cd), 32'd1);
        chk("clr_en", 32'(en), 32'd0);
        step(1);
        chk("run_cd",  32'(cd),  32'd0);
        chk("run_en",  32'(en),  32'd1);
        chk("run_cai", 32'(cai), 32'd1);
        chk("run_q0",  32'(q),   32'd0);
        step(4);
        cap = 1'b1;
        step(1);
        cap = 1'b0;
        chk("cap_data",  32'(data),  32'd4);
        chk("cap_valid", 32'(valid), 32'd1);
        step(1);
        chk("cap_valid_fall", 32'(valid), 32'd0);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("stop_en", 32'(en), 32'd0);
        chk("stop_q",  32'(q),  32'd7);
        step(1);
        chk("final_data",  32'(data),  32'd7);
        chk("final_valid", 32'(valid), 32'd1);
        step(1);
        chk("final_valid_fall", 32'(valid), 32'd0);

        // Busy port: second capture is dropped, first sample held.
        ready = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        step(2);
        cap = 1'b1;
        step(1);
        cap = 1'b0;
        chk("busy_data1", 32'(data), 32'd2);
        step(2);
        cap = 1'b1;
        step(1);
        cap = 1'b0;
        chk("busy_lost",  32'(lost),  32'd1);
        chk("busy_data2", 32'(data),  32'd2);
        chk("busy_valid", 32'(valid), 32'd1);
        step(1);
        chk("busy_q7",    32'(q),    32'd7);
        chk("busy_data3", 32'(data), 32'd2);

        // Asynchronous reset mid-run, no clock edge needed.
        cdn = 1'b0;
        #1;
        chk("arst_cd",    32'(cd),    32'd1);
        chk("arst_en",    32'(en),    32'd0);
        chk("arst_cai",   32'(cai),   32'd0);
        chk("arst_data",  32'(data),  32'd0);
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_lost",  32'(lost),  32'd0);
        chk("arst_q",     32'(q),     32'd7);
        #2;
        cdn   = 1'b1;
        ready = 1'b1;
        step(1);

        // 20 cycles in RUN: wrap (or saturate) and final capture.
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        for (int i = 1; i <= 19; i++) begin
            step(1);
            if (i == 15) begin
                chk("ovf_pre", 32'(ovf), 32'd0);
                chk("q15",     32'(q),   32'd15);
`ifdef CBU_CAP_SAT_EN
                chk("sat_en_off", 32'(en), 32'd0);
`endif
            end
            if (i == 16) begin
                chk("ovf_edge", 32'(ovf), 32'd1);
`ifdef CBU_CAP_SAT_EN
                chk("q16_sat", 32'(q), 32'd15);
`else
                chk("q16_wrap", 32'(q), 32'd0);
`endif
            end
        end
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("stop20_en",  32'(en),  32'd0);
        chk("stop20_ovf", 32'(ovf), 32'd1);
`ifdef CBU_CAP_SAT_EN
        chk("stop20_q", 32'(q), 32'd15);
        step(1);
        chk("stop20_data", 32'(data), 32'd15);
`else
        chk("stop20_q", 32'(q), 32'd4);
        step(1);
        chk("stop20_data", 32'(data), 32'd4);
`endif
        step(1);

        // STOP and CAP together, then port busy for 3 cycles.
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        step(2);
        stop = 1'b1;
        cap  = 1'b1;
        step(1);
        stop  = 1'b0;
        cap   = 1'b0;
        ready = 1'b0;
        chk("sc_data",  32'(data),  32'd2);
        chk("sc_valid", 32'(valid), 32'd1);
        step(3);
        chk("sc_held_data", 32'(data), 32'd2);
        chk("sc_held_q",    32'(q),    32'd3);
        ready = 1'b1;
        step(1);
        chk("sc_final_data",  32'(data),  32'd3);
        chk("sc_final_valid", 32'(valid), 32'd1);
        chk("sc_lost",        32'(lost),  32'd0);
        step(1);
        chk("sc_valid_fall", 32'(valid), 32'd0);

        // START and STOP together in RUN: restart clears OVF and LOST.
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        step(16);
        chk("rs_ovf_set", 32'(ovf), 32'd1);
        ready = 1'b0;
        cap   = 1'b1;
        step(2);
        cap = 1'b0;
        chk("rs_lost_set", 32'(lost), 32'd1);
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        chk("rs_clr_cd", 32'(cd), 32'd1);
        chk("rs_clr_en", 32'(en), 32'd0);
        step(1);
        chk("rs_ovf_clr",  32'(ovf),   32'd0);
        chk("rs_lost_clr", 32'(lost),  32'd0);
        chk("rs_run_en",   32'(en),    32'd1);
        chk("rs_valid",    32'(valid), 32'd1);
        ready = 1'b1;
        step(2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
